// File: rtl/seg7_pkg.sv
// Shared constants for the four-digit seven-segment scanner.
// Glyphs are active-low with bit 0 = segment a through bit 6 = segment g.
package seg7_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // One complete set of display contents, used for both staging and committed data.
  typedef struct packed {
    logic [NDIG*4-1:0] digits;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   blink;
  } disp_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low segment pattern; non-decimal values show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_blank) begin
      o_seg = SEG_OFF;
    end else begin
      case (i_nibble)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed four-digit seven-segment driver with frame-aligned commit,
// leading-zero blanking, per-digit blink and an anode-off guard at each slot start.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYC    = 2,
  parameter int BLINK_FRAMES = 125,
  parameter bit LZB_EN       = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NDIG*4-1:0]   digits_in,
  input  logic [NDIG-1:0]     dp_in,
  input  logic [NDIG-1:0]     blink_in,
  input  logic                load,
  output logic                pending,
  output logic [NDIG-1:0]     an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);
  localparam logic [FR_W-1:0]  FR_MAX    = FR_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [FR_W-1:0]  r_frameCnt;
  logic             r_phase;
  disp_t            r_stage;
  disp_t            r_disp;
  logic             r_pending;
  logic [NDIG-1:0]  r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frameTick;

  logic             w_slotTick;
  logic             w_frameBoundary;
  disp_t            w_incoming;
  logic [3:0]       w_nibble;
  logic             w_dpReq;
  logic             w_dark;
  logic             w_lzBlank;
  logic [6:0]       w_seg;

  assign w_slotTick      = (r_cnt == CNT_MAX);
  assign w_frameBoundary = w_slotTick && (r_idx == 2'd3);
  assign w_incoming      = {digits_in, dp_in, blink_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slotTick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load landing on the boundary itself bypasses staging so it is not held a whole extra frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage   <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_stage <= w_incoming;
      end
      if (w_frameBoundary) begin
        r_pending <= 1'b0;
        if (load) begin
          r_disp <= w_incoming;
        end else if (r_pending) begin
          r_disp <= r_stage;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_frameBoundary) begin
      if (r_frameCnt == FR_MAX) begin
        r_frameCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  assign w_nibble = r_disp.digits[{r_idx, 2'b00} +: 4];
  assign w_dpReq  = r_disp.dp[r_idx];
  assign w_dark   = r_phase && r_disp.blink[r_idx];

  always_comb begin
    w_lzBlank = 1'b0;
    if (LZB_EN) begin
      case (r_idx)
        2'd3:    w_lzBlank = (r_disp.digits[15:12] == 4'd0);
        2'd2:    w_lzBlank = (r_disp.digits[15:8] == 8'd0);
        2'd1:    w_lzBlank = (r_disp.digits[15:4] == 12'd0);
        default: w_lzBlank = 1'b0;
      endcase
    end
  end

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_lzBlank | w_dark),
    .o_seg    (w_seg)
  );

  // Blanked digits keep their decimal point; blink-dark digits lose it too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an        <= 4'hF;
      r_seg       <= SEG_OFF;
      r_dp        <= 1'b1;
      r_frameTick <= 1'b0;
    end else begin
      r_an        <= (r_cnt < GUARD_END) ? 4'hF : ~(4'b0001 << r_idx);
      r_seg       <= w_seg;
      r_dp        <= ~(w_dpReq && !w_dark);
      r_frameTick <= w_frameBoundary;
    end
  end

  assign pending    = r_pending;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frameTick;

endmodule
